// File: rtl/interrupt_controller.sv
// Interrupt source controller: edge-latched requests, fixed-priority pick,
// alert/acknowledge handshake, in-service tracking and post-return hold-off.
module interrupt_controller #(
    parameter int unsigned NUM_SRC    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    parameter int unsigned HOLDOFF    = 3,
    localparam int unsigned ID_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic [NUM_SRC-1:0] irq_enable,
    input  logic               interrupt_mask,
    input  logic               interrupt,
    input  logic               reti,
    output logic               alert,
    output logic [31:0]        vector_pc,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALERT,
        S_SERVICE,
        S_COOLDOWN
    } state_e;

    localparam logic [2:0] HO_LAST = (HOLDOFF == 0) ? 3'd0 : 3'(HOLDOFF - 1);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [31:0]        vpc_q, vpc_d;
    logic [2:0]         cnt_q, cnt_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clr;
    logic [ID_W-1:0]    win;
    logic               found;
    logic               ack;

    assign rise = irq_req & ~irq_q;
    assign elig = pending_q & irq_enable;
    assign ack  = (state_q == S_ALERT) && interrupt;

    // Lowest set index wins
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (elig[i] && !found) begin
                win   = ID_W'(i);
                found = 1'b1;
            end
        end
    end

    // A fresh edge on the acknowledged source survives the clear
    always_comb begin
        clr = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            clr[i] = ack && (id_q == ID_W'(i));
        end
        pending_d = (pending_q & ~clr) | rise;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vpc_d   = vpc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (found && !interrupt_mask) begin
                    state_d = S_ALERT;
                    id_d    = win;
                    vpc_d   = VEC_BASE + (32'(win) * VEC_STRIDE);
                end
            end
            S_ALERT: begin
                if (interrupt) begin
                    state_d = S_SERVICE;
                end else if (interrupt_mask) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (reti) begin
                    cnt_d   = 3'd0;
                    state_d = (HOLDOFF == 0) ? S_IDLE : S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == HO_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            id_q      <= '0;
            vpc_q     <= VEC_BASE;
            cnt_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_req;
            pending_q <= pending_d;
            id_q      <= id_d;
            vpc_q     <= vpc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign alert      = (state_q == S_ALERT);
    assign in_service = (state_q == S_SERVICE);
    assign vector_pc  = vpc_q;
    assign irq_id     = id_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: HOLDOFF=3 main instance plus
// a HOLDOFF=0 instance for the immediate-return case.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_req, irq_en;
    logic        mask, intr, reti;
    logic        alert, in_svc;
    logic [31:0] vpc;
    logic [1:0]  id;
    logic [3:0]  pend;

    logic [3:0]  b_irq, b_en;
    logic        b_mask, b_intr, b_reti;
    logic        b_alert, b_in_svc;
    logic [31:0] b_vpc;
    logic [1:0]  b_id;
    logic [3:0]  b_pend;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    interrupt_controller #(.NUM_SRC(4), .HOLDOFF(3)) dut (
        .clk(clk), .rst(rst),
        .irq_req(irq_req), .irq_enable(irq_en),
        .interrupt_mask(mask), .interrupt(intr), .reti(reti),
        .alert(alert), .vector_pc(vpc), .irq_id(id),
        .in_service(in_svc), .pending(pend)
    );

    interrupt_controller #(.NUM_SRC(4), .HOLDOFF(0)) dut_h0 (
        .clk(clk), .rst(rst),
        .irq_req(b_irq), .irq_enable(b_en),
        .interrupt_mask(b_mask), .interrupt(b_intr), .reti(b_reti),
        .alert(b_alert), .vector_pc(b_vpc), .irq_id(b_id),
        .in_service(b_in_svc), .pending(b_pend)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; irq_req = '0; irq_en = 4'hF;
        mask = 1'b0; intr = 1'b0; reti = 1'b0;
        b_irq = '0; b_en = 4'hF; b_mask = 1'b0; b_intr = 1'b0; b_reti = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_alert", 32'(alert), 0);
        chk("rst_insvc", 32'(in_svc), 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_id", 32'(id), 0);
        chk("rst_vpc", vpc, 32'h100);

        // single request on source 2
        irq_req = 4'b0100;
        tick(1);
        chk("s1_pend", 32'(pend), 32'h4);
        chk("s1_alert_early", 32'(alert), 0);
        tick(1);
        chk("s1_alert", 32'(alert), 1);
        chk("s1_id", 32'(id), 2);
        chk("s1_vpc", vpc, 32'h120);
        tick(2);
        chk("s1_alert_hold", 32'(alert), 1);
        intr = 1'b1;
        tick(1);
        intr = 1'b0;
        chk("s1_ack_alert", 32'(alert), 0);
        chk("s1_ack_insvc", 32'(in_svc), 1);
        chk("s1_ack_pend", 32'(pend), 0);

        // source 1 arrives during service, hold-off after reti
        irq_req = 4'b0010;
        tick(1);
        chk("ho_pend", 32'(pend), 32'h2);
        chk("ho_no_nest", 32'(alert), 0);
        reti = 1'b1;
        tick(1);
        reti = 1'b0;
        irq_req = '0;
        chk("ho_r1_insvc", 32'(in_svc), 0);
        chk("ho_r1_alert", 32'(alert), 0);
        tick(1);
        chk("ho_r2_alert", 32'(alert), 0);
        tick(1);
        chk("ho_r3_alert", 32'(alert), 0);
        tick(1);
        chk("ho_r4_alert", 32'(alert), 0);
        tick(1);
        chk("ho_r5_alert", 32'(alert), 1);
        chk("ho_r5_id", 32'(id), 1);
        chk("ho_r5_vpc", vpc, 32'h110);
        intr = 1'b1;
        tick(1);
        intr = 1'b0;
        chk("ho_ack_pend", 32'(pend), 0);
        reti = 1'b1;
        tick(1);
        reti = 1'b0;
        tick(4);
        chk("ho_idle_alert", 32'(alert), 0);

        // priority and freeze
        irq_req = 4'b1010;
        tick(1);
        chk("pr_pend", 32'(pend), 32'hA);
        tick(1);
        chk("pr_alert", 32'(alert), 1);
        chk("pr_id", 32'(id), 1);
        chk("pr_vpc", vpc, 32'h110);
        irq_req = 4'b1011;
        tick(1);
        chk("fz_pend", 32'(pend), 32'hB);
        chk("fz_id", 32'(id), 1);
        chk("fz_vpc", vpc, 32'h110);
        // spurious reti while alerting
        reti = 1'b1;
        tick(1);
        reti = 1'b0;
        chk("sp_reti_alert", 32'(alert), 1);
        chk("sp_reti_insvc", 32'(in_svc), 0);
        // re-edge on source 1 in the ack cycle
        irq_req = 4'b1001;
        tick(1);
        irq_req = 4'b1011;
        intr = 1'b1;
        tick(1);
        intr = 1'b0;
        chk("col_insvc", 32'(in_svc), 1);
        chk("col_pend", 32'(pend), 32'hB);
        reti = 1'b1;
        tick(1);
        reti = 1'b0;
        tick(5);
        chk("pr2_alert", 32'(alert), 1);
        chk("pr2_id", 32'(id), 0);
        chk("pr2_vpc", vpc, 32'h100);
        intr = 1'b1;
        tick(1);
        intr = 1'b0;
        chk("pr2_pend", 32'(pend), 32'hA);
        reti = 1'b1;
        tick(1);
        reti = 1'b0;
        tick(5);
        chk("pr3_id", 32'(id), 1);
        chk("pr3_alert", 32'(alert), 1);
        intr = 1'b1;
        tick(1);
        intr = 1'b0;
        chk("pr3_pend", 32'(pend), 32'h8);

        // mask and spurious interrupt in IDLE
        mask = 1'b1;
        reti = 1'b1;
        tick(1);
        reti = 1'b0;
        tick(6);
        chk("mk_alert", 32'(alert), 0);
        chk("mk_pend", 32'(pend), 32'h8);
        intr = 1'b1;
        tick(1);
        intr = 1'b0;
        chk("sp_int_alert", 32'(alert), 0);
        chk("sp_int_insvc", 32'(in_svc), 0);
        chk("sp_int_pend", 32'(pend), 32'h8);
        mask = 1'b0;
        tick(1);
        chk("mk_rel_alert", 32'(alert), 1);
        chk("mk_rel_id", 32'(id), 3);
        chk("mk_rel_vpc", vpc, 32'h130);
        mask = 1'b1;
        tick(1);
        chk("mk_drop_alert", 32'(alert), 0);
        chk("mk_drop_pend", 32'(pend), 32'h8);
        mask = 1'b0;
        tick(1);
        chk("mk_again_alert", 32'(alert), 1);
        irq_en = 4'b1110;
        irq_req = '0;
        intr = 1'b1;
        tick(1);
        intr = 1'b0;
        chk("mk_ack_pend", 32'(pend), 0);
        reti = 1'b1;
        tick(1);
        reti = 1'b0;
        tick(4);

        // disabled source is held until enabled
        irq_req = 4'b0001;
        tick(1);
        chk("en_pend", 32'(pend), 32'h1);
        tick(2);
        chk("en_held_alert", 32'(alert), 0);
        irq_en = 4'hF;
        tick(1);
        chk("en_alert", 32'(alert), 1);
        chk("en_id", 32'(id), 0);
        intr = 1'b1;
        tick(1);
        intr = 1'b0;

        // reset during service with events pending, line held through release
        irq_req = 4'b1011;
        tick(1);
        chk("rs_pend", 32'(pend), 32'hA);
        chk("rs_insvc", 32'(in_svc), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rs_alert", 32'(alert), 0);
        chk("rs_insvc0", 32'(in_svc), 0);
        chk("rs_pend0", 32'(pend), 0);
        chk("rs_id", 32'(id), 0);
        chk("rs_vpc", vpc, 32'h100);
        tick(1);
        chk("rs_rel_pend", 32'(pend), 32'hB);
        chk("rs_rel_alert0", 32'(alert), 0);
        tick(1);
        chk("rs_rel_alert", 32'(alert), 1);
        chk("rs_rel_id", 32'(id), 0);

        // HOLDOFF=0 instance
        b_irq = 4'b0010;
        tick(2);
        chk("h0_alert", 32'(b_alert), 1);
        b_intr = 1'b1;
        b_irq = '0;
        tick(1);
        b_intr = 1'b0;
        chk("h0_insvc", 32'(b_in_svc), 1);
        b_irq = 4'b0010;
        tick(1);
        chk("h0_pend", 32'(b_pend), 32'h2);
        b_reti = 1'b1;
        tick(1);
        b_reti = 1'b0;
        chk("h0_r1_insvc", 32'(b_in_svc), 0);
        chk("h0_r1_alert", 32'(b_alert), 0);
        tick(1);
        chk("h0_r2_alert", 32'(b_alert), 1);
        chk("h0_r2_id", 32'(b_id), 1);
        chk("h0_r2_vpc", b_vpc, 32'h110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
